// File: rtl/fp_normalize.sv
// Post-add normalizer for IEEE-754 single precision: handles carry-out, zero,
// overflow and underflow, and left-shifts one bit per cycle until the hidden one is set.
module fp_normalize (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [24:0] in_mant,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow,
   output logic        underflow
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [7:0]  exp_q, exp_d;
   logic [23:0] mant_q, mant_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        overflow_q, overflow_d;
   logic        underflow_q, underflow_d;

   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      result_d    = result_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d      = in_sign;
               exp_d       = in_exp;
               mant_d      = in_mant[23:0];
               zero_d      = 1'b0;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
               if (in_mant == 25'd0) begin
                  result_d = {in_sign, 31'd0};
                  zero_d   = 1'b1;
                  state_d  = DONE;
               end else if (in_mant[24]) begin
                  // Carry-out: one right shift normalizes; bit 0 is truncated
                  if (in_exp >= 8'hFE) begin
                     result_d   = {in_sign, 8'hFF, 23'd0};
                     overflow_d = 1'b1;
                  end else begin
                     result_d = {in_sign, in_exp + 8'd1, in_mant[23:1]};
                  end
                  state_d = DONE;
               end else if (in_exp == 8'hFF) begin
                  result_d   = {in_sign, 8'hFF, 23'd0};
                  overflow_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (mant_q[23] && exp_q != 8'd0) begin
               result_d = {sign_q, exp_q, mant_q[22:0]};
               state_d  = DONE;
            end else if (exp_q <= 8'd1) begin
               // Exponent would drop into denormal range: flush to zero
               result_d    = {sign_q, 31'd0};
               underflow_d = 1'b1;
               state_d     = DONE;
            end else begin
               mant_d = {mant_q[22:0], 1'b0};
               exp_d  = exp_q - 8'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         exp_q       <= 8'd0;
         mant_q      <= 24'd0;
         result_q    <= 32'd0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed vector bench for fp_normalize: latency, packed result and flags per vector,
// plus hold-stability and mid-operation reset sequences.
module tb_fp_normalize;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sign;
   logic [7:0]  in_exp;
   logic [24:0] in_mant;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        zero, overflow, underflow;

   int checks = 0;
   int fails  = 0;

   fp_normalize dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [31:0] res;
      logic [2:0]  flg;   // {zero, overflow, underflow}
      int          lat;   // edges after capture until out_valid
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // Present one input, wait for out_valid; does not complete the handshake.
   task automatic issue(input vec_t v, input string tag);
      int cyc;
      @(negedge clk);
      check({tag, " in_ready before capture"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " in_ready after capture"}, {31'd0, in_ready}, 32'd0);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, cyc, v.lat);
      check({tag, " result"}, result, v.res);
      check({tag, " flags"}, {29'd0, zero, overflow, underflow}, {29'd0, v.flg});
   endtask

   task automatic handshake(input string tag, input logic [31:0] res_exp);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
      check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
      check({tag, " result held after handshake"}, result, res_exp);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 8'h80, 25'h0800000, 32'h40000000, 3'b000, 2};
      vecs[1]  = '{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3'b000, 1};
      vecs[2]  = '{1'b0, 8'h96, 25'h0000001, 32'h3F800000, 3'b000, 25};
      vecs[3]  = '{1'b1, 8'h55, 25'h0000000, 32'h80000000, 3'b100, 1};
      vecs[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b010, 1};
      vecs[5]  = '{1'b0, 8'h02, 25'h0000100, 32'h00000000, 3'b001, 3};
      vecs[6]  = '{1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 3'b010, 1};
      vecs[7]  = '{1'b0, 8'hFD, 25'h1000000, 32'h7F000000, 3'b000, 1};
      vecs[8]  = '{1'b0, 8'h7F, 25'h1000003, 32'h40000001, 3'b000, 1};
      vecs[9]  = '{1'b1, 8'h81, 25'h0400001, 32'hC0000002, 3'b000, 3};
      vecs[10] = '{1'b1, 8'h00, 25'h0800000, 32'h80000000, 3'b001, 2};

      rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 25'd0;
      out_ready = 1'b0;
      #12;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset flags", {29'd0, zero, overflow, underflow}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i], $sformatf("vec%0d", i));
         handshake($sformatf("vec%0d", i), vecs[i].res);
      end

      // Underflow result held with out_ready low; new in_valid ignored meanwhile
      issue(vecs[5], "hold");
      @(negedge clk);
      in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h80; in_mant = 25'h0800000;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold c%0d out_valid", c), {31'd0, out_valid}, 32'd1);
         check($sformatf("hold c%0d result", c), result, 32'h0);
         check($sformatf("hold c%0d flags", c), {29'd0, zero, overflow, underflow}, 32'd1);
      end
      in_valid = 1'b0;
      handshake("hold", 32'h0);

      // Reset pulsed mid-NORM discards the operation
      @(negedge clk);
      in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h96; in_mant = 25'h0000001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            check("midrst stale out_valid", {31'd0, out_valid}, 32'd0);
            break;
         end
      end
      issue(vecs[1], "postrst");
      handshake("postrst", vecs[1].res);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
